cache_mc_resp: RTL

CACHE_MC_RESP -- requirements
Module: cache_mc_resp

---
 rtl/cache_mc_resp.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cache_mc_resp.sv
// ============================================================================
// Module   : cache_mc_resp
// Purpose  : Cache line mover between the cache data SRAM and backing memory.
//            Accepts one command at a time from the cache controller and
//            either fills a line (memory -> cache way) or writes a line back
//            (lowest selected cache way -> memory), one word per memory
//            request, then pulses an acknowledge.
// Ports    : clk, reset (async, active-low)
//            phy_*  : command handshake (vld/rdy), command word, done pulse
//            mem_*  : backing memory request/grant, write data, read return
//            cl_*   : cache data SRAM address, per-way write enable (active
//                     low), write data, all-way read data (1-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_mc_resp #(
    parameter int ADDR_WIDTH       = 32,
    parameter int CLINE_SIZE_WORD  = 4,
    parameter int CLINE_ADDR_WIDTH = 7,
    parameter int CLINE_WORD_WIDTH = 32,
    parameter int NUM_WAYS         = 4
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               phy_vld_i,
    output logic                                               phy_rdy_o,
    input  logic [ADDR_WIDTH+NUM_WAYS:0]                       phy_cmd_i,
    output logic                                               phy_ack_o,
    output logic                                               mem_req_o,
    input  logic                                               mem_gnt_i,
    output logic                                               mem_we_o,
    output logic [ADDR_WIDTH-1:0]                              mem_addr_o,
    output logic [CLINE_WORD_WIDTH-1:0]                        mem_wdat_o,
    input  logic                                               mem_rvld_i,
    input  logic [CLINE_WORD_WIDTH-1:0]                        mem_rdat_i,
    output logic [CLINE_ADDR_WIDTH+$clog2(CLINE_SIZE_WORD)-1:0] cl_addr_o,
    output logic [NUM_WAYS-1:0]                                cl_web_o,
    output logic [CLINE_WORD_WIDTH-1:0]                        cl_wdat_o,
    input  logic [CLINE_WORD_WIDTH*NUM_WAYS-1:0]               cl_rdat_i
);

    localparam int c_OFS = $clog2(CLINE_SIZE_WORD);
    localparam int c_W   = CLINE_WORD_WIDTH;
    localparam logic [c_OFS-1:0] c_LAST = c_OFS'(CLINE_SIZE_WORD - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WB_RD   = 3'd3,
        S_WB_CAP  = 3'd4,
        S_WB_REQ  = 3'd5,
        S_ACK     = 3'd6
    } state_t;

    state_t                       r_state;
    logic                         r_op;
    logic [NUM_WAYS-1:0]          r_way;
    logic [ADDR_WIDTH-c_OFS-1:0]  r_line;    // command address without word offset
    logic [c_OFS-1:0]             r_cnt;     // word index within the line
    logic [c_W-1:0]               r_wb_data; // word captured from the SRAM for writeback

    logic                         w_fill_wr;
    logic                         w_last;
    logic [c_W-1:0]               w_cap_data;
    logic                         w_unused_lsb;

    // The word offset of the command address is replaced by the counter.
    assign w_unused_lsb = ^phy_cmd_i[c_OFS-1:0];

    assign w_last    = (r_cnt == c_LAST);
    // The SRAM write happens in the same cycle the memory returns data so
    // that it lands at the address of the word being filled, before the
    // counter advances.
    assign w_fill_wr = (r_state == S_RD_WAIT) && mem_rvld_i;

    // Lowest set way wins: scan from the top so lower indices overwrite.
    always_comb begin
        w_cap_data = '0;
        for (int k = NUM_WAYS - 1; k >= 0; k--) begin
            if (r_way[k]) begin
                w_cap_data = cl_rdat_i[k*c_W +: c_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_op      <= 1'b0;
            r_way     <= '0;
            r_line    <= '0;
            r_cnt     <= '0;
            r_wb_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (phy_vld_i) begin
                        r_op    <= phy_cmd_i[ADDR_WIDTH+NUM_WAYS];
                        r_way   <= phy_cmd_i[ADDR_WIDTH +: NUM_WAYS];
                        r_line  <= phy_cmd_i[ADDR_WIDTH-1:c_OFS];
                        r_cnt   <= '0;
                        r_state <= phy_cmd_i[ADDR_WIDTH+NUM_WAYS] ? S_WB_RD : S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (mem_gnt_i) begin
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (mem_rvld_i) begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= w_last ? S_ACK : S_RD_REQ;
                    end
                end
                S_WB_RD: begin
                    // Address is presented this cycle; data returns next cycle.
                    r_state <= S_WB_CAP;
                end
                S_WB_CAP: begin
                    r_wb_data <= w_cap_data;
                    r_state   <= S_WB_REQ;
                end
                S_WB_REQ: begin
                    if (mem_gnt_i) begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= w_last ? S_ACK : S_WB_RD;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign phy_rdy_o  = (r_state == S_IDLE);
    assign phy_ack_o  = (r_state == S_ACK);
    assign mem_req_o  = (r_state == S_RD_REQ) || (r_state == S_WB_REQ);
    assign mem_we_o   = (r_state == S_WB_REQ) && r_op;
    assign mem_addr_o = {r_line, r_cnt};
    assign mem_wdat_o = r_wb_data;
    assign cl_addr_o  = {r_line[CLINE_ADDR_WIDTH-1:0], r_cnt};
    assign cl_web_o   = w_fill_wr ? ~r_way : {NUM_WAYS{1'b1}};
    assign cl_wdat_o  = w_fill_wr ? mem_rdat_i : '0;

endmodule

`default_nettype wire
